fifo_umbrales: RTL and testbench

- Synchronous FIFO with programmable almost-full/almost-empty thresholds.
- Five instances sit between the link stages and the control state machine: one main FIFO, two VC FIFOs and two D FIFOs.
- Thresholds come from the state machine's latched Umbrales_*_internos outputs.
- Each instance's empty and error flags form one bit of FIFO_empties[4:0] and FIFO_errors[4:0] back into that machine.

---
 rtl/fifo_umbrales_pkg.sv | 16 +
 rtl/fifo_umbrales_mem.sv | 27 ++
 rtl/fifo_umbrales.sv | 109 ++++++++++
 tb/tb_fifo_umbrales.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_umbrales_pkg.sv
// Shared constants for the threshold FIFOs placed between the link stages and the control machine.
package fifo_umbrales_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 2;
  localparam int UMBRAL_WIDTH   = 2;
  localparam int NUM_FIFOS      = 5;

  // Bit positions of each instance inside FIFO_empties[4:0] / FIFO_errors[4:0].
  localparam int IDX_MF  = 0;
  localparam int IDX_VC0 = 1;
  localparam int IDX_VC1 = 2;
  localparam int IDX_D0  = 3;
  localparam int IDX_D1  = 4;

endpackage

// File: rtl/fifo_umbrales_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write, combinational read.
// No reset; a location holds garbage until it has been written.
module fifo_umbrales_mem
  import fifo_umbrales_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_umbrales.sv
// Sync FIFO with programmable almost-full/almost-empty thresholds; 1-cycle registered read, writes to a full FIFO only pass with a same-cycle read.
// FIFO_UMBRALES_ERROR_STICKY_EN: error latches until reset instead of pulsing one cycle per overflow/underflow.
module fifo_umbrales
  import fifo_umbrales_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_enable,
  input  logic                    rd_enable,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [UMBRAL_WIDTH-1:0] umbral_almost_full,
  input  logic [UMBRAL_WIDTH-1:0] umbral_almost_empty,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic                    error,
  output logic [ADDR_WIDTH:0]     count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Wide enough that count + threshold cannot wrap.
  localparam int CW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  rd_acc, wr_acc, overflow, underflow;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (CW'(count_q) <= CW'(umbral_almost_empty));
  assign almost_full  = ((CW'(count_q) + CW'(umbral_almost_full)) >= CW'(DEPTH));

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc    = rd_enable && !empty;
  assign wr_acc    = wr_enable && (!full || rd_acc);
  assign overflow  = wr_enable && full && !rd_enable;
  assign underflow = rd_enable && empty;

  fifo_umbrales_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk      (clk),
    .wr_en_i  (wr_acc),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(data_in),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(mem_rd_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      data_out_d = mem_rd_data;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
`ifdef FIFO_UMBRALES_ERROR_STICKY_EN
    error_d = error_q || overflow || underflow;
`else
    error_d = overflow || underflow;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign error     = error_q;
  assign count     = count_q;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Self-checking bench for fifo_umbrales: scoreboard queue of expected read data, one task per scenario.
module tb_fifo_umbrales;

`ifdef FIFO_UMBRALES_ERROR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_enable, rd_enable;
  logic [5:0] data_in;
  logic [1:0] umbral_almost_full, umbral_almost_empty;
  logic [5:0] data_out;
  logic       valid_out, empty, full, almost_empty, almost_full, error;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] model_q[$];
  logic [5:0] exp_q[$];
  logic [5:0] exp_d;
  bit         exp_valid;
  bit         exp_err;

  fifo_umbrales dut (
    .clk                (clk),
    .reset              (reset),
    .wr_enable          (wr_enable),
    .rd_enable          (rd_enable),
    .data_in            (data_in),
    .umbral_almost_full (umbral_almost_full),
    .umbral_almost_empty(umbral_almost_empty),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .empty              (empty),
    .full               (full),
    .almost_empty       (almost_empty),
    .almost_full        (almost_full),
    .error              (error),
    .count              (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of stimulus and advance the model; returns at posedge + 1.
  task automatic drive(input bit wr, input bit rd, input logic [5:0] din);
    bit was_full, was_empty, rd_ok, wr_ok;
    was_full  = (model_q.size() == 4);
    was_empty = (model_q.size() == 0);
    rd_ok     = rd && !was_empty;
    wr_ok     = wr && (!was_full || rd_ok);
    if (STICKY) exp_err = exp_err | (wr && was_full && !rd) | (rd && was_empty);
    else        exp_err = (wr && was_full && !rd) | (rd && was_empty);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(din);
    exp_valid = rd_ok;
    wr_enable = wr;
    rd_enable = rd;
    data_in   = din;
    @(posedge clk); #1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_q.delete();
    exp_q.delete();
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0; data_in = '0;
    umbral_almost_full = 2'd2; umbral_almost_empty = 2'd1;
    exp_valid = 1'b0; exp_err = 1'b0;
    #12;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_checks++; if (data_out !== 6'd0) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_out); end
    @(posedge clk); #1;
    reset = 1'b1;
    // Idle a cycle out of reset: nothing may change.
    drive(1'b0, 1'b0, 6'd0);
    n_checks++; if (empty !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL idle_after_reset: empty %b count %0d want 1/0", empty, count); end
  endtask

  task automatic test_fill();
    umbral_almost_full = 2'd1; umbral_almost_empty = 2'd1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 6'(i));
      n_checks++; if (count !== 3'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
      n_checks++; if (almost_full !== (i >= 3)) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, almost_full, (i >= 3)); end
      n_checks++; if (full !== (i == 4)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 4)); end
      n_checks++; if (almost_empty !== (i <= 1)) begin n_fail++; $display("FAIL fill_almost_empty[%0d]: got %b want %b", i, almost_empty, (i <= 1)); end
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 6'd0);
      n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, valid_out); end
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL drain_scoreboard[%0d]: got empty queue want entry", i); end
      else begin
        exp_d = exp_q.pop_front();
        if (data_out !== exp_d || exp_d !== 6'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_out, 6'(i)); end
      end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    drive(1'b0, 1'b0, 6'd0);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL drain_valid_drop: got %b want 0", valid_out); end
    n_checks++; if (data_out !== 6'h04) begin n_fail++; $display("FAIL drain_data_hold: got %h want 04", data_out); end
  endtask

  task automatic test_thresholds();
    drive(1'b1, 1'b0, 6'h11);
    drive(1'b1, 1'b0, 6'h12);
    umbral_almost_empty = 2'd2; #1;
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL thr_ae2_cnt2: got %b want 1", almost_empty); end
    umbral_almost_empty = 2'd1; #1;
    n_checks++; if (almost_empty !== 1'b0) begin n_fail++; $display("FAIL thr_ae1_cnt2: got %b want 0", almost_empty); end
    umbral_almost_full = 2'd2; #1;
    n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL thr_af2_cnt2: got %b want 1", almost_full); end
    umbral_almost_full = 2'd0; #1;
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL thr_af0_cnt2: got %b want 0", almost_full); end
    drive(1'b1, 1'b0, 6'h13);
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL thr_af0_cnt3: got %b want 0", almost_full); end
    drive(1'b1, 1'b0, 6'h14);
    n_checks++; if (almost_full !== 1'b1 || full !== 1'b1) begin n_fail++; $display("FAIL thr_af0_cnt4: got af %b full %b want 1/1", almost_full, full); end
    umbral_almost_full = 2'd1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 6'd0);
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL thr_scoreboard[%0d]: got empty queue want entry", i); end
      else begin
        exp_d = exp_q.pop_front();
        if (valid_out !== 1'b1 || data_out !== exp_d) begin n_fail++; $display("FAIL thr_drain[%0d]: got %b/%h want 1/%h", i, valid_out, data_out, exp_d); end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 6'h0A + 6'(i));
    drive(1'b1, 1'b0, 6'h3F);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_error: got %b want 1", error); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", count); end
    drive(1'b0, 1'b0, 6'd0);
    n_checks++; if (error !== STICKY) begin n_fail++; $display("FAIL ovf_error_after: got %b want %b", error, STICKY); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 6'd0);
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL ovf_scoreboard[%0d]: got empty queue want entry", i); end
      else begin
        exp_d = exp_q.pop_front();
        if (data_out !== exp_d || exp_d !== 6'h0A + 6'(i)) begin n_fail++; $display("FAIL ovf_contents[%0d]: got %h want %h", i, data_out, 6'h0A + 6'(i)); end
      end
    end
    n_checks++; if (error !== STICKY) begin n_fail++; $display("FAIL ovf_error_later: got %b want %b", error, STICKY); end
    pulse_reset();
    n_checks++; if (error !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL ovf_reset_clear: got err %b count %0d want 0/0", error, count); end
  endtask

  task automatic test_underflow_simul();
    drive(1'b1, 1'b1, 6'h15);
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL udf_count: got %0d want 1", count); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL udf_valid: got %b want 0", valid_out); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL udf_error: got %b want 1", error); end
    drive(1'b0, 1'b1, 6'd0);
    n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL udf_scoreboard: got empty queue want entry"); end
    else begin
      exp_d = exp_q.pop_front();
      if (valid_out !== 1'b1 || data_out !== exp_d || exp_d !== 6'h15) begin n_fail++; $display("FAIL udf_readback: got %b/%h want 1/15", valid_out, data_out); end
    end
    n_checks++; if (error !== exp_err) begin n_fail++; $display("FAIL udf_error_after: got %b want %b", error, exp_err); end
    pulse_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 6'h20 + 6'(i));
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 6'h30 + 6'(i));
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 4", i, count); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL b2b_error[%0d]: got %b want 0", i, error); end
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_scoreboard[%0d]: got empty queue want entry", i); end
      else begin
        exp_d = exp_q.pop_front();
        if (valid_out !== 1'b1 || data_out !== exp_d) begin n_fail++; $display("FAIL b2b_data[%0d]: got %b/%h want 1/%h", i, valid_out, data_out, exp_d); end
      end
    end
    // Mid-burst asynchronous reset between clock edges.
    wr_enable = 1'b1; rd_enable = 1'b1; data_in = 6'h3A;
    #3;
    reset = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL async_rst_count: got cnt %0d empty %b full %b want 0/1/0", count, empty, full); end
    n_checks++; if (valid_out !== 1'b0 || data_out !== 6'd0) begin n_fail++; $display("FAIL async_rst_data: got %b/%h want 0/00", valid_out, data_out); end
    n_checks++; if (error !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags: got err %b ae %b af %b want 0/1/0", error, almost_empty, almost_full); end
    model_q.delete(); exp_q.delete(); exp_err = 1'b0; exp_valid = 1'b0;
    @(posedge clk); #1;
    wr_enable = 1'b0; rd_enable = 1'b0;
    reset = 1'b1;
    drive(1'b1, 1'b0, 6'h2A);
    drive(1'b0, 1'b1, 6'd0);
    n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL post_rst_scoreboard: got empty queue want entry"); end
    else begin
      exp_d = exp_q.pop_front();
      if (valid_out !== 1'b1 || data_out !== exp_d || exp_d !== 6'h2A) begin n_fail++; $display("FAIL post_rst_readback: got %b/%h want 1/2a", valid_out, data_out); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_thresholds();
    test_overflow();
    test_underflow_simul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
